cpu_run_ctrl: RTL and testbench

//  Run-control block inside the 5-stage pipelined CPU. It owns the CPU side of the clk/rst/hlt interface.

---
 rtl/cpu_run_ctrl.sv | 126 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run-control for the 5-stage pipeline: post-reset warm-up, HLT acceptance and drain,
// and saturating cycle / retired-instruction counters.
module cpu_run_ctrl #(
    parameter int RST_HOLD     = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hlt_id,
    input  logic             stall,
    input  logic             flush,
    input  logic             wb_valid,
    output logic             pc_freeze,
    output logic             running,
    output logic             hlt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [3:0]       HOLD_LAST  = 4'(RST_HOLD - 1);
    localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] drain_q, drain_d;
    logic       pc_freeze_q, running_q, hlt_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        drain_d = drain_q;
        case (state_q)
            ST_INIT: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            ST_RUN: begin
                // A flushed HLT is a squashed instruction; a stalled one is retried next cycle.
                if (hlt_id && !stall && !flush) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    if (drain_q <= 4'd1) begin
                        state_d = ST_HALTED;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            hold_q      <= 4'd0;
            drain_q     <= 4'd0;
            pc_freeze_q <= 1'b1;
            running_q   <= 1'b0;
            hlt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            drain_q     <= drain_d;
            pc_freeze_q <= (state_d != ST_RUN);
            running_q   <= (state_d == ST_RUN);
            hlt_q       <= (state_d == ST_HALTED);
        end
    end

    logic       count_en;
    logic [1:0] cnt_inc;

    assign count_en   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign cnt_inc[0] = count_en;
    assign cnt_inc[1] = count_en && wb_valid;

    // Index 0 counts active cycles, index 1 counts retirements.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign pc_freeze = pc_freeze_q;
    assign running   = running_q;
    assign hlt       = hlt_q;
    assign cycle_cnt = g_cnt[0].cnt_q;
    assign instr_cnt = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: expected outputs are queued per cycle and
// compared one sampling point after each rising edge.
module tb_cpu_run_ctrl;

    logic        clk;
    logic        rst;
    logic        hlt_id;
    logic        stall;
    logic        flush;
    logic        wb_valid;
    logic        pc_freeze, running, hlt;
    logic [15:0] cycle_cnt, instr_cnt;
    logic        s_pc_freeze, s_running, s_hlt;
    logic [3:0]  s_cycle_cnt, s_instr_cnt;

    typedef struct packed {
        logic        pf;
        logic        run;
        logic        hl;
        logic [15:0] cyc;
        logic [15:0] ins;
    } obs_t;

    typedef struct packed {
        logic h;
        logic s;
        logic f;
        logic w;
    } stim_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    cpu_run_ctrl #(.RST_HOLD(2), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hlt_id(hlt_id), .stall(stall), .flush(flush),
        .wb_valid(wb_valid), .pc_freeze(pc_freeze), .running(running), .hlt(hlt),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    cpu_run_ctrl #(.RST_HOLD(2), .DRAIN_CYCLES(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .hlt_id(hlt_id), .stall(stall), .flush(flush),
        .wb_valid(wb_valid), .pc_freeze(s_pc_freeze), .running(s_running), .hlt(s_hlt),
        .cycle_cnt(s_cycle_cnt), .instr_cnt(s_instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(logic pf, logic run, logic hl, int cyc, int ins);
        obs_t o;
        o.pf  = pf;
        o.run = run;
        o.hl  = hl;
        o.cyc = 16'(cyc);
        o.ins = 16'(ins);
        return o;
    endfunction

    function automatic stim_t S(logic h, logic s, logic f, logic w);
        stim_t st;
        st.h = h;
        st.s = s;
        st.f = f;
        st.w = w;
        return st;
    endfunction

    function automatic obs_t observe();
        return mk(pc_freeze, running, hlt, int'(cycle_cnt), int'(instr_cnt));
    endfunction

    function automatic obs_t observe_sat();
        return mk(s_pc_freeze, s_running, s_hlt, int'(s_cycle_cnt), int'(s_instr_cnt));
    endfunction

    task automatic tick(input stim_t st);
        hlt_id   = st.h;
        stall    = st.s;
        flush    = st.f;
        wb_valid = st.w;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        hlt_id = 1'b0; stall = 1'b0; flush = 1'b0; wb_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(S(0, 0, 0, 0));
        tick(S(0, 0, 0, 0));
    endtask

    task automatic test_reset();
        obs_t got, exp;
        stim_t st[$];
        hlt_id = 1'b0; stall = 1'b0; flush = 1'b0; wb_valid = 1'b0; rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        got = observe();
        exp = mk(1, 0, 0, 0, 0);
        n_checks++;
        if (got !== exp) $display("FAIL reset_assert got %h required %h", got, exp);
        else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        got = observe();
        n_checks++;
        if (got !== exp) $display("FAIL reset_hold got %h required %h", got, exp);
        else n_pass++;
        rst = 1'b0;
        st.push_back(S(0, 0, 0, 1)); sb.push_back(mk(1, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1)); sb.push_back(mk(0, 1, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(0, 1, 0, 1, 0));
        st.push_back(S(0, 0, 0, 1)); sb.push_back(mk(0, 1, 0, 2, 1));
        foreach (st[i]) begin
            tick(st[i]);
            got = observe();
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL reset_seq c%0d got pf=%b run=%b hlt=%b cyc=%0d ins=%0d required pf=%b run=%b hlt=%b cyc=%0d ins=%0d",
                         i, got.pf, got.run, got.hl, got.cyc, got.ins, exp.pf, exp.run, exp.hl, exp.cyc, exp.ins);
            else n_pass++;
        end
    endtask

    task automatic test_halt_no_stall();
        obs_t got, exp;
        stim_t st[$];
        apply_reset();
        st.push_back(S(0, 0, 0, 1)); sb.push_back(mk(0, 1, 0, 1, 1));
        st.push_back(S(1, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 2, 1));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 3, 1));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 4, 1));
        st.push_back(S(0, 0, 0, 1)); sb.push_back(mk(1, 0, 1, 5, 2));
        st.push_back(S(1, 0, 0, 1)); sb.push_back(mk(1, 0, 1, 5, 2));
        st.push_back(S(0, 1, 1, 1)); sb.push_back(mk(1, 0, 1, 5, 2));
        foreach (st[i]) begin
            tick(st[i]);
            got = observe();
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL halt_no_stall c%0d got pf=%b run=%b hlt=%b cyc=%0d ins=%0d required pf=%b run=%b hlt=%b cyc=%0d ins=%0d",
                         i, got.pf, got.run, got.hl, got.cyc, got.ins, exp.pf, exp.run, exp.hl, exp.cyc, exp.ins);
            else n_pass++;
        end
    endtask

    task automatic test_halt_stall();
        obs_t got, exp;
        stim_t st[$];
        apply_reset();
        st.push_back(S(1, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 1, 0));
        st.push_back(S(1, 0, 1, 0)); sb.push_back(mk(1, 0, 0, 2, 0));
        st.push_back(S(0, 1, 0, 1)); sb.push_back(mk(1, 0, 0, 3, 1));
        st.push_back(S(0, 1, 0, 0)); sb.push_back(mk(1, 0, 0, 4, 1));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 5, 1));
        st.push_back(S(0, 0, 0, 1)); sb.push_back(mk(1, 0, 1, 6, 2));
        st.push_back(S(0, 0, 0, 1)); sb.push_back(mk(1, 0, 1, 6, 2));
        foreach (st[i]) begin
            tick(st[i]);
            got = observe();
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL halt_stall c%0d got pf=%b run=%b hlt=%b cyc=%0d ins=%0d required pf=%b run=%b hlt=%b cyc=%0d ins=%0d",
                         i, got.pf, got.run, got.hl, got.cyc, got.ins, exp.pf, exp.run, exp.hl, exp.cyc, exp.ins);
            else n_pass++;
        end
    endtask

    task automatic test_squash();
        obs_t got, exp;
        stim_t st[$];
        apply_reset();
        st.push_back(S(1, 0, 1, 0)); sb.push_back(mk(0, 1, 0, 1, 0));
        st.push_back(S(1, 1, 1, 0)); sb.push_back(mk(0, 1, 0, 2, 0));
        st.push_back(S(1, 1, 0, 0)); sb.push_back(mk(0, 1, 0, 3, 0));
        st.push_back(S(1, 1, 0, 1)); sb.push_back(mk(0, 1, 0, 4, 1));
        st.push_back(S(1, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 5, 1));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 6, 1));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 7, 1));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(1, 0, 1, 8, 1));
        foreach (st[i]) begin
            tick(st[i]);
            got = observe();
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL squash c%0d got pf=%b run=%b hlt=%b cyc=%0d ins=%0d required pf=%b run=%b hlt=%b cyc=%0d ins=%0d",
                         i, got.pf, got.run, got.hl, got.cyc, got.ins, exp.pf, exp.run, exp.hl, exp.cyc, exp.ins);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        obs_t got, exp;
        int   sat;
        apply_reset();
        for (int i = 1; i <= 20; i++) begin
            sat = (i > 15) ? 15 : i;
            sb.push_back(mk(0, 1, 0, i, i));
            sb.push_back(mk(0, 1, 0, sat, sat));
            tick(S(0, 0, 0, 1));
            got = observe();
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL count16 c%0d got cyc=%0d ins=%0d run=%b required cyc=%0d ins=%0d run=%b",
                         i, got.cyc, got.ins, got.run, exp.cyc, exp.ins, exp.run);
            else n_pass++;
            got = observe_sat();
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL saturation c%0d got cyc=%0d ins=%0d run=%b required cyc=%0d ins=%0d run=%b",
                         i, got.cyc, got.ins, got.run, exp.cyc, exp.ins, exp.run);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        obs_t  got, exp;
        stim_t st[$];
        int    pulse_a, pulse_b;
        apply_reset();
        st.push_back(S(1, 0, 0, 1)); sb.push_back(mk(1, 0, 0, 1, 1));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 2, 1));
        pulse_a = st.size();
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(0, 1, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(0, 1, 0, 1, 0));
        st.push_back(S(1, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 2, 0));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 3, 0));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 4, 0));
        st.push_back(S(0, 0, 0, 1)); sb.push_back(mk(1, 0, 1, 5, 1));
        st.push_back(S(0, 0, 0, 0)); sb.push_back(mk(1, 0, 1, 5, 1));
        pulse_b = st.size();
        st.push_back(S(0, 0, 0, 1)); sb.push_back(mk(1, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1)); sb.push_back(mk(0, 1, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1)); sb.push_back(mk(0, 1, 0, 1, 1));
        foreach (st[i]) begin
            if (i == pulse_a || i == pulse_b) begin
                #2;
                rst = 1'b1;
                #1;
                got = observe();
                exp = mk(1, 0, 0, 0, 0);
                n_checks++;
                if (got !== exp)
                    $display("FAIL async_reset before c%0d got pf=%b run=%b hlt=%b cyc=%0d ins=%0d required pf=1 run=0 hlt=0 cyc=0 ins=0",
                             i, got.pf, got.run, got.hl, got.cyc, got.ins);
                else n_pass++;
                #2;
                rst = 1'b0;
            end
            tick(st[i]);
            got = observe();
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp)
                $display("FAIL async_seq c%0d got pf=%b run=%b hlt=%b cyc=%0d ins=%0d required pf=%b run=%b hlt=%b cyc=%0d ins=%0d",
                         i, got.pf, got.run, got.hl, got.cyc, got.ins, exp.pf, exp.run, exp.hl, exp.cyc, exp.ins);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_halt_no_stall();
        test_halt_stall();
        test_squash();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
